sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of SRAM_CTR: grants one requester at a time,
// holds the command through BUSY, then pulses ack and returns read data.
module sram_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_rd_req,
   input  logic        p0_wr_req,
   input  logic [15:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_rd_req,
   input  logic        p1_wr_req,
   input  logic [15:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p0_stall,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        p1_stall,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [15:0] address,
   output logic [31:0] writeData,
   input  logic [31:0] readData,
   input  logic        SRAM_NOT_READY,
   output logic        grant,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        first_q, first_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        op_rd_q, op_rd_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] p0_rdata_q, p0_rdata_d;
   logic [31:0] p1_rdata_q, p1_rdata_d;
   logic        err_q, err_d;

   logic p0_req, p1_req, win;

   assign p0_req = p0_rd_req | p0_wr_req;
   assign p1_req = p1_rd_req | p1_wr_req;

   // Tie goes to port 0 in fixed mode, else to the port not served last.
   always_comb begin
      win = 1'b0;
      if (p0_req && p1_req) begin
         if (FIXED_PRIO != 0) win = 1'b0;
         else                 win = ~last_q;
      end else begin
         win = ~p0_req;
      end
   end

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      cnt_d      = cnt_q;
      op_rd_d    = op_rd_q;
      grant_d    = grant_q;
      last_d     = last_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      err_d      = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               grant_d = win;
               addr_d  = win ? p1_addr : p0_addr;
               wdata_d = win ? p1_wdata : p0_wdata;
               op_rd_d = win ? p1_rd_req : p0_rd_req;
               first_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            first_d = 1'b0;
            // SRAM_CTR raises NOT_READY only combinationally in cycle one.
            if (!SRAM_NOT_READY && !first_q) begin
               state_d = S_RESP;
               if (op_rd_q) begin
                  if (grant_q) p1_rdata_d = readData;
                  else         p0_rdata_d = readData;
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         first_q    <= 1'b0;
         cnt_q      <= 8'd0;
         op_rd_q    <= 1'b0;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         addr_q     <= 16'd0;
         wdata_q    <= 32'd0;
         p0_rdata_q <= 32'd0;
         p1_rdata_q <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         cnt_q      <= cnt_d;
         op_rd_q    <= op_rd_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
         err_q      <= err_d;
      end
   end

   assign MEM_R_EN    = (state_q == S_BUSY) &  op_rd_q;
   assign MEM_W_EN    = (state_q == S_BUSY) & ~op_rd_q;
   assign address     = addr_q;
   assign writeData   = wdata_q;
   assign grant       = grant_q;
   assign timeout_err = err_q;
   assign p0_ack      = (state_q == S_RESP) & ~grant_q;
   assign p1_ack      = (state_q == S_RESP) &  grant_q;
   assign p0_rdata    = p0_rdata_q;
   assign p1_rdata    = p1_rdata_q;
   assign p0_stall    = p0_req & ~p0_ack;
   assign p1_stall    = p1_req & ~p1_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: round-robin and fixed-priority instances sharing
// one clock/reset, each fronting a small behavioural SRAM_CTR model.
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
   logic [1:0]  p0_ack, p1_ack, p0_stall, p1_stall;
   logic [1:0]  mem_r_en, mem_w_en, nr, grant, terr;
   logic [15:0] p0_addr [2];
   logic [15:0] p1_addr [2];
   logic [15:0] address [2];
   logic [31:0] p0_wdata [2];
   logic [31:0] p1_wdata [2];
   logic [31:0] p0_rdata [2];
   logic [31:0] p1_rdata [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data [2];
   logic [31:0] mem [2][256];
   int          scnt [2];
   int          acks [2][2];
   bit          hang;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      int          inst;
      int          port;
      logic [31:0] data;
      int          at;
   } exp_t;
   exp_t sb[$];

   for (genvar i = 0; i < 2; i++) begin : g_dut
      sram_arbiter #(.FIXED_PRIO(i), .TIMEOUT(8)) u_dut (
         .clk(clk), .rst(rst),
         .p0_rd_req(p0_rd_req[i]), .p0_wr_req(p0_wr_req[i]),
         .p0_addr(p0_addr[i]), .p0_wdata(p0_wdata[i]),
         .p1_rd_req(p1_rd_req[i]), .p1_wr_req(p1_wr_req[i]),
         .p1_addr(p1_addr[i]), .p1_wdata(p1_wdata[i]),
         .p0_ack(p0_ack[i]), .p0_rdata(p0_rdata[i]),
         .p0_stall(p0_stall[i]),
         .p1_ack(p1_ack[i]), .p1_rdata(p1_rdata[i]),
         .p1_stall(p1_stall[i]),
         .MEM_R_EN(mem_r_en[i]), .MEM_W_EN(mem_w_en[i]),
         .address(address[i]), .writeData(write_data[i]),
         .readData(read_data[i]), .SRAM_NOT_READY(nr[i]),
         .grant(grant[i]), .timeout_err(terr[i])
      );
   end

   // SRAM_CTR model: not ready for the first five enabled cycles.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nr[i] = (mem_r_en[i] | mem_w_en[i]) & (hang | (scnt[i] < 5));
         read_data[i] = mem[i][address[i][7:0]];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (mem_r_en[i] | mem_w_en[i]) scnt[i] <= scnt[i] + 1;
         else                           scnt[i] <= 0;
         if (p0_ack[i]) acks[i][0] <= acks[i][0] + 1;
         if (p1_ack[i]) acks[i][1] <= acks[i][1] + 1;
         if (rst) begin
            for (int j = 0; j < 256; j++) mem[i][j] <= {4{8'(j)}};
            mem[i][8'h12] <= 32'hDEADBEEF;
            mem[i][8'h02] <= 32'hCAFEF00D;
         end else if (mem_w_en[i] && !nr[i]) begin
            mem[i][address[i][7:0]] <= write_data[i];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic ack_of(input int i, input int p);
      return (p == 0) ? p0_ack[i] : p1_ack[i];
   endfunction

   task automatic clr(input int i, input int p);
      if (p == 0) begin
         p0_rd_req[i] = 1'b0;
         p0_wr_req[i] = 1'b0;
      end else begin
         p1_rd_req[i] = 1'b0;
         p1_wr_req[i] = 1'b0;
      end
   endtask

   task automatic push(input int i, input int p, input logic [31:0] d,
                       input int at);
      exp_t e;
      e.inst = i;
      e.port = p;
      e.data = d;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic collect(input int budget, input bit drop);
      exp_t e;
      int   k;
      e = sb.pop_front();
      step();
      k = 1;
      while (!ack_of(e.inst, e.port) && k < budget) begin
         step();
         k++;
      end
      chk("ack_seen", 32'(ack_of(e.inst, e.port)), 1);
      chk("ack_cycle", 32'(cyc), 32'(e.at));
      chk("rdata", (e.port == 1) ? p1_rdata[e.inst] : p0_rdata[e.inst],
          e.data);
      if (drop) clr(e.inst, e.port);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   int t0, a0, a1;

   initial begin
      rst  = 1'b1;
      hang = 1'b0;
      p0_rd_req = '0; p0_wr_req = '0;
      p1_rd_req = '0; p1_wr_req = '0;
      for (int i = 0; i < 2; i++) begin
         p0_addr[i] = '0; p1_addr[i] = '0;
         p0_wdata[i] = '0; p1_wdata[i] = '0;
      end
      do_reset();

      for (int i = 0; i < 2; i++) begin
         chk("rst_ack", 32'({p0_ack[i], p1_ack[i]}), 0);
         chk("rst_en", 32'({mem_r_en[i], mem_w_en[i]}), 0);
         chk("rst_addr", 32'(address[i]), 0);
         chk("rst_wdata", write_data[i], 0);
         chk("rst_grant", 32'(grant[i]), 0);
         chk("rst_err", 32'(terr[i]), 0);
         chk("rst_rdata0", p0_rdata[i], 0);
         chk("rst_rdata1", p1_rdata[i], 0);
      end

      // single read
      t0 = cyc;
      p0_rd_req[0] = 1'b1;
      p0_addr[0]   = 16'h0012;
      push(0, 0, 32'hDEADBEEF, t0 + 7);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t1_ren", 32'(mem_r_en[0]), 1);
         chk("t1_stall", 32'(p0_stall[0]), 1);
      end
      chk("t1_addr", 32'(address[0]), 32'h12);
      collect(4, 1);
      chk("t1_grant", 32'(grant[0]), 0);
      chk("t1_resp_en", 32'(mem_r_en[0]), 0);
      step();
      chk("t1_ack_off", 32'(p0_ack[0]), 0);

      // simultaneous requests, round-robin
      do_reset();
      t0 = cyc;
      p0_wr_req[0] = 1'b1;
      p0_addr[0]   = 16'h0001;
      p0_wdata[0]  = 32'h11112222;
      p1_rd_req[0] = 1'b1;
      p1_addr[0]   = 16'h0002;
      push(0, 0, 32'h0, t0 + 7);
      push(0, 1, 32'hCAFEF00D, t0 + 15);
      step();
      chk("t2_wen", 32'(mem_w_en[0]), 1);
      chk("t2_wdata", write_data[0], 32'h11112222);
      chk("t2_grant0", 32'(grant[0]), 0);
      collect(10, 1);
      collect(12, 1);
      chk("t2_mem", mem[0][1], 32'h11112222);
      p0_rd_req[0] = 1'b1;
      p0_addr[0]   = 16'h0012;
      p1_rd_req[0] = 1'b1;
      push(0, 0, 32'hDEADBEEF, t0 + 23);
      push(0, 1, 32'hCAFEF00D, t0 + 31);
      step(2);
      chk("t2_tie_grant", 32'(grant[0]), 0);
      collect(10, 1);
      collect(12, 1);

      // fixed priority starves port 1
      do_reset();
      t0 = cyc;
      a1 = acks[1][1];
      p0_rd_req[1] = 1'b1;
      p0_addr[1]   = 16'h0012;
      p1_rd_req[1] = 1'b1;
      p1_addr[1]   = 16'h0002;
      for (int j = 0; j < 5; j++) begin
         push(1, 0, 32'hDEADBEEF, t0 + 7 + 8 * j);
         collect(10, 0);
         chk("t3_p1_stall", 32'(p1_stall[1]), 1);
         chk("t3_grant", 32'(grant[1]), 0);
      end
      chk("t3_p1_acks", 32'(acks[1][1] - a1), 0);
      clr(1, 0);
      clr(1, 1);

      // command held after grant
      do_reset();
      t0 = cyc;
      p1_rd_req[0] = 1'b1;
      p1_addr[0]   = 16'h0040;
      push(0, 1, 32'h40404040, t0 + 7);
      step(3);
      p1_addr[0] = 16'h0080;
      for (int k = 3; k <= 6; k++) begin
         if (k > 3) step();
         chk("t4_addr", 32'(address[0]), 32'h40);
      end
      chk("t4_grant", 32'(grant[0]), 1);
      collect(4, 1);
      chk("t4_addr_resp", 32'(address[0]), 32'h40);
      step();

      // timeout with SRAM stuck busy
      t0 = cyc;
      hang = 1'b1;
      p1_rd_req[0] = 1'b1;
      p1_addr[0]   = 16'h0080;
      push(0, 1, 32'h40404040, t0 + 9);
      collect(14, 1);
      chk("t5_err", 32'(terr[0]), 1);
      hang = 1'b0;
      step(3);
      chk("t5_err_sticky", 32'(terr[0]), 1);
      t0 = cyc;
      p0_rd_req[0] = 1'b1;
      p0_addr[0]   = 16'h0012;
      push(0, 0, 32'hDEADBEEF, t0 + 7);
      collect(10, 1);
      chk("t5_err_after", 32'(terr[0]), 1);
      step();

      // reset in the middle of BUSY
      p0_rd_req[0] = 1'b1;
      step(3);
      chk("t6_ren", 32'(mem_r_en[0]), 1);
      a0 = acks[0][0];
      rst = 1'b1;
      step();
      chk("t6_en", 32'({mem_r_en[0], mem_w_en[0]}), 0);
      chk("t6_ack", 32'(p0_ack[0]), 0);
      chk("t6_rdata", p0_rdata[0], 0);
      chk("t6_err", 32'(terr[0]), 0);
      rst = 1'b0;
      clr(0, 0);
      step(10);
      chk("t6_no_ack", 32'(acks[0][0] - a0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
